// File: rtl/jtag_debug_pkg.sv
// Shared IR codes and jdo bit positions for the system-clock JTAG debug command decoder.
// Pure declarations: no latency, no backpressure.
package jtag_debug_pkg;

  typedef enum logic [1:0] {
    IR_OCIMEM    = 2'd0,
    IR_TRACEMEM  = 2'd1,
    IR_BREAK     = 2'd2,
    IR_TRACECTRL = 2'd3
  } ir_e;

  localparam int J_ACT3   = 37;
  localparam int J_ACT2   = 36;
  localparam int J_ACT1   = 35;
  localparam int J_ACT0   = 34;
  localparam int J_TRCTRL = 15;

endpackage

// File: rtl/jtag_sync_edge.sv
// Level synchroniser + history flop, emitting a registered one-cycle pulse per rising edge.
// Latency SYNC_STAGES+1 cycles from first sampling flop to edge_out; no backpressure.
module jtag_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic edge_out
);

  localparam int WW = $clog2(SYNC_STAGES + 2);
  localparam logic [WW-1:0] WARM_DONE = WW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   edge_q, edge_d;
  logic [WW-1:0]          warm_q, warm_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    hist_d = sync_q[SYNC_STAGES-1];
    warm_d = (warm_q == WARM_DONE) ? warm_q : warm_q + WW'(1);
    // A level already high at reset release reaches the history compare before warm-up ends.
    edge_d = sync_q[SYNC_STAGES-1] & ~hist_q & (warm_q == WARM_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      edge_q <= 1'b0;
      warm_q <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      edge_q <= edge_d;
      warm_q <= warm_d;
    end
  end

  assign edge_out = edge_q;

endmodule

// File: rtl/jtag_debug_sysclk_cmd_decoder.sv
// Brings TCK-side update strobes into clk, captures sr/ir and decodes one-cycle take_* pulses.
// Latency SYNC_STAGES+2 cycles from vs_udr sampled high to strobe; no backpressure.
module jtag_debug_sysclk_cmd_decoder
  import jtag_debug_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SR_W        = 38,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SR_W-1:0]  sr,
  input  logic [1:0]       ir_in,
  input  logic             vs_udr,
  input  logic             vs_uir,
  output logic [SR_W-1:0]  jdo,
  output logic             take_action_ocimem_a,
  output logic             take_action_ocimem_b,
  output logic             take_no_action_ocimem_a,
  output logic             take_action_tracemem_a,
  output logic             take_action_tracemem_b,
  output logic             take_no_action_tracemem_a,
  output logic             take_action_break_a,
  output logic             take_action_break_b,
  output logic             take_action_break_c,
  output logic             take_no_action_break_a,
  output logic             take_no_action_break_b,
  output logic             take_no_action_break_c,
  output logic             take_action_tracectrl,
  output logic [CNT_W-1:0] cmd_count
);

  logic udr_edge, uir_edge;

  jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
    .clk(clk), .reset(reset), .async_in(vs_udr), .edge_out(udr_edge)
  );

  jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
    .clk(clk), .reset(reset), .async_in(vs_uir), .edge_out(uir_edge)
  );

  ir_e              ir_q, ir_d;
  logic [SR_W-1:0]  jdo_q, jdo_d;
  logic             act_q, act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    ir_d  = uir_edge ? ir_e'(ir_in) : ir_q;
    jdo_d = udr_edge ? sr : jdo_q;
    act_d = udr_edge;
    cnt_d = udr_edge ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q  <= IR_OCIMEM;
      jdo_q <= '0;
      act_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ir_q  <= ir_d;
      jdo_q <= jdo_d;
      act_q <= act_d;
      cnt_q <= cnt_d;
    end
  end

  // ir_q and jdo_q load on the same edge as act_q, so a simultaneous IR update steers this pulse.
  always_comb begin
    take_action_ocimem_a      = 1'b0;
    take_action_ocimem_b      = 1'b0;
    take_no_action_ocimem_a   = 1'b0;
    take_action_tracemem_a    = 1'b0;
    take_action_tracemem_b    = 1'b0;
    take_no_action_tracemem_a = 1'b0;
    take_action_break_a       = 1'b0;
    take_action_break_b       = 1'b0;
    take_action_break_c       = 1'b0;
    take_no_action_break_a    = 1'b0;
    take_no_action_break_b    = 1'b0;
    take_no_action_break_c    = 1'b0;
    take_action_tracectrl     = 1'b0;
    if (act_q) begin
      unique case (ir_q)
        IR_OCIMEM: begin
          take_action_ocimem_a    = ~jdo_q[J_ACT1] &  jdo_q[J_ACT0];
          take_no_action_ocimem_a = ~jdo_q[J_ACT1] & ~jdo_q[J_ACT0];
          take_action_ocimem_b    =  jdo_q[J_ACT1];
        end
        IR_TRACEMEM: begin
          take_action_tracemem_a    = ~jdo_q[J_ACT3] &  jdo_q[J_ACT2];
          take_no_action_tracemem_a = ~jdo_q[J_ACT3] & ~jdo_q[J_ACT2];
          take_action_tracemem_b    =  jdo_q[J_ACT3];
        end
        IR_BREAK: begin
          take_action_break_a    =  jdo_q[J_ACT3] & ~jdo_q[J_ACT2];
          take_action_break_b    =  jdo_q[J_ACT3] &  jdo_q[J_ACT2] & ~jdo_q[J_ACT1];
          take_action_break_c    =  jdo_q[J_ACT3] &  jdo_q[J_ACT2] &  jdo_q[J_ACT1];
          take_no_action_break_a = ~jdo_q[J_ACT3] & ~jdo_q[J_ACT2];
          take_no_action_break_b = ~jdo_q[J_ACT3] &  jdo_q[J_ACT2] & ~jdo_q[J_ACT1];
          take_no_action_break_c = ~jdo_q[J_ACT3] &  jdo_q[J_ACT2] &  jdo_q[J_ACT1];
        end
        IR_TRACECTRL: take_action_tracectrl = jdo_q[J_TRCTRL];
        default: ;
      endcase
    end
  end

  assign jdo       = jdo_q;
  assign cmd_count = cnt_q;

endmodule

// File: tb/tb_jtag_debug_sysclk_cmd_decoder.sv
// Randomised scoreboard bench for the system-clock JTAG debug command decoder.
module tb_jtag_debug_sysclk_cmd_decoder;

  localparam int S     = 2;
  localparam int SR_W  = 38;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [SR_W-1:0]  sr;
  logic [1:0]       ir_in;
  logic             vs_udr, vs_uir;
  logic [SR_W-1:0]  jdo;
  logic             t_oa, t_ob, n_oa, t_ta, t_tb, n_ta;
  logic             t_ba, t_bb, t_bc, n_ba, n_bb, n_bc, t_tc;
  logic [CNT_W-1:0] cmd_count;

  jtag_debug_sysclk_cmd_decoder #(.SYNC_STAGES(S), .SR_W(SR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .sr(sr), .ir_in(ir_in), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .jdo(jdo),
    .take_action_ocimem_a(t_oa), .take_action_ocimem_b(t_ob), .take_no_action_ocimem_a(n_oa),
    .take_action_tracemem_a(t_ta), .take_action_tracemem_b(t_tb), .take_no_action_tracemem_a(n_ta),
    .take_action_break_a(t_ba), .take_action_break_b(t_bb), .take_action_break_c(t_bc),
    .take_no_action_break_a(n_ba), .take_no_action_break_b(n_bb), .take_no_action_break_c(n_bc),
    .take_action_tracectrl(t_tc), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  // Bit order: oci_a oci_b no_oci_a | trm_a trm_b no_trm_a | brk_a brk_b brk_c | nbrk_a nbrk_b nbrk_c | trctrl
  logic [12:0] dut_stb;
  assign dut_stb = {t_oa, t_ob, n_oa, t_ta, t_tb, n_ta, t_ba, t_bb, t_bc, n_ba, n_bb, n_bc, t_tc};

  typedef struct {
    int               due;
    logic [12:0]      stb;
    logic [SR_W-1:0]  jdo;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  int               vec_cnt = 0;
  int               err_cnt = 0;
  int               cyc = 0;
  bit               rst_edge = 1'b0;
  logic [CNT_W-1:0] prev_cnt;
  int               ir_m = 0;
  logic [CNT_W-1:0] cnt_m = '0;

  // Reference decode straight from the command tables: which single strobe a command selects.
  function automatic logic [12:0] model(input int ir, input logic [SR_W-1:0] d);
    logic [12:0] v;
    int          sel;
    v = '0;
    case (ir)
      0: v[d[35] ? 11 : (d[34] ? 12 : 10)] = 1'b1;
      1: v[d[37] ? 8 : (d[36] ? 9 : 7)] = 1'b1;
      2: begin
        sel = !d[36] ? 0 : (!d[35] ? 1 : 2);
        v[d[37] ? 6 - sel : 3 - sel] = 1'b1;
      end
      default: v[0] = d[15];
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_edge = reset;
  end

  always @(negedge clk) begin
    if (rst_edge) begin
      chk("rst_stb", 64'(dut_stb), 64'd0);
      chk("rst_cnt", 64'(cmd_count), 64'd0);
      chk("rst_jdo", 64'(jdo), 64'd0);
      prev_cnt = '0;
    end else if (cmd_count !== prev_cnt) begin
      if (sb.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_cmd: got count %0h strobes %0h expected no command", cmd_count, dut_stb);
      end else begin
        mon_e = sb.pop_front();
        chk("latency", 64'(cyc), 64'(mon_e.due));
        chk("strobes", 64'(dut_stb), 64'(mon_e.stb));
        chk("jdo", 64'(jdo), 64'(mon_e.jdo));
        chk("cmd_count", 64'(cmd_count), 64'(mon_e.cnt));
      end
      prev_cnt = cmd_count;
    end else if (dut_stb != '0) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL stray_strobe: got %0h expected 0", dut_stb);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [SR_W-1:0] rnd_sr();
    return {6'($urandom), 32'($urandom)};
  endfunction

  task automatic do_update(input bit u_ir, input bit u_dr, input logic [1:0] ir, input logic [SR_W-1:0] d, input int hi);
    exp_t e;
    @(negedge clk);
    if (u_ir) begin
      ir_in  = ir;
      ir_m   = int'(ir);
      vs_uir = 1'b1;
    end else begin
      ir_in = 2'($urandom);
    end
    if (u_dr) begin
      sr     = d;
      vs_udr = 1'b1;
      cnt_m  = cnt_m + 1'b1;
      e.due  = cyc + S + 2;
      e.stb  = model(ir_m, d);
      e.jdo  = d;
      e.cnt  = cnt_m;
      sb.push_back(e);
    end
    idle(hi);
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    idle(S + 3 + $urandom_range(0, 2));
  endtask

  logic [SR_W-1:0]  d;
  logic [CNT_W-1:0] start_cnt;
  bit               bu, bd;

  initial begin
    reset = 1'b1; vs_udr = 1'b1; vs_uir = 1'b0; sr = '0; ir_in = '0;
    idle(4);
    // Level already high at reset release must not produce a command.
    reset = 1'b0;
    idle(10);
    chk("t1_cnt", 64'(cmd_count), 64'd0);
    vs_udr = 1'b0;
    idle(S + 3);

    do_update(1'b1, 1'b0, 2'd0, '0, 1);
    d = rnd_sr(); d[35:34] = 2'b01;
    do_update(1'b0, 1'b1, 2'd0, d, 1);
    chk("t2_jdo", 64'(jdo), 64'(d));
    chk("t2_cnt", 64'(cmd_count), 64'd1);

    do_update(1'b1, 1'b0, 2'd2, '0, 2);
    d = rnd_sr(); d[37:35] = 3'b110;
    do_update(1'b0, 1'b1, 2'd0, d, 1);
    d = rnd_sr(); d[37:35] = 3'b010;
    do_update(1'b0, 1'b1, 2'd0, d, 3);

    d = rnd_sr(); d[15] = 1'b1;
    do_update(1'b1, 1'b1, 2'd3, d, 1);

    for (int i = 0; i < 60; i++) begin
      bu = 1'($urandom);
      bd = 1'($urandom) | ~bu;
      do_update(bu, bd, 2'($urandom), rnd_sr(), $urandom_range(1, 4));
    end

    do_update(1'b0, 1'b1, 2'd0, rnd_sr(), 20);

    start_cnt = cnt_m;
    for (int i = 0; i < 256; i++) do_update(1'b0, 1'b1, 2'd0, rnd_sr(), 1);
    chk("t5_wrap", 64'(cmd_count), 64'(start_cnt));

    // Reset lands on the edge that would raise act: the command is lost.
    do_update(1'b1, 1'b0, 2'd1, '0, 1);
    @(negedge clk);
    sr = rnd_sr();
    vs_udr = 1'b1;
    idle(S + 1);
    reset = 1'b1;
    vs_udr = 1'b0;
    ir_m = 0;
    cnt_m = '0;
    idle(2);
    reset = 1'b0;
    chk("t6_jdo", 64'(jdo), 64'd0);
    chk("t6_cnt", 64'(cmd_count), 64'd0);
    idle(S + 3);
    d = rnd_sr(); d[35:34] = 2'b00;
    do_update(1'b0, 1'b1, 2'd0, d, 1);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
